dm_bank_ctrl: RTL and testbench
===============================

Name: dm_bank_ctrl

Overview:
- Parametrised data-memory controller for the MEM stage; successor to the single-cycle combinational-read data memory.
- Accepts one load/store request at a time over a valid/ready handshake and returns read data or a write acknowledgement after a configurable latency.
- Performs byte/half/word sub-word merge and sign/zero extension; flags misaligned and out-of-range accesses as exceptions for the CP0 path.
- Clears memory contents by sweep after reset, because an asynchronous reset cannot clear the array.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words; power of two, at least 4.
- READ_LAT, 1, load latency in cycles from accept to rsp_valid; legal values 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  PC of the issuing instruction, used for trace and exception reporting.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and for exceptions.
- rsp_exc  out  1  access faulted.
- rsp_exc_code  out  2  1 = misaligned, 2 = out of range; 0 when rsp_exc = 0.
- rsp_pc  out  32  req_pc captured for this response.

Behaviour:
- States: CLEAR, IDLE, WAIT, RESP.
- Reset (reset_n = 0, asynchronous):
  - State goes to CLEAR and the sweep counter goes to 0.
  - All outputs are 0 and any pending response is discarded.
  - Reset asserted mid-operation behaves the same way: the in-flight store is not guaranteed and the sweep restarts.
- CLEAR:
  - Writes 0 to word[cnt] and increments cnt each cycle; req_ready = 0.
  - After word DEPTH_WORDS-1 is written, goes to IDLE, so CLEAR lasts exactly DEPTH_WORDS cycles.
- IDLE:
  - req_ready = 1; a request is accepted on a cycle with req_valid & req_ready (cycle N).
  - Load: go to WAIT if READ_LAT > 1, otherwise to RESP; rsp_valid first rises at cycle N + READ_LAT.
  - Store: the write is committed at the accept edge; go to RESP with rsp_valid at N+1.
  - Faulted request: no memory write; go to RESP at N+1 regardless of READ_LAT.
- WAIT: counts READ_LAT-1 cycles, then goes to RESP. The array is read at accept and the data is held in a pipeline register.
- RESP:
  - rsp_valid = 1; rsp_* stay stable until rsp_ready = 1, then go to IDLE.
  - req_ready = 0 throughout, so only one request is outstanding; there is no request/response overlap in the same cycle.
- Address rules, with off = req_addr - BASE_ADDR:
  - Out of range when off >= 4*DEPTH_WORDS, including wrap below BASE_ADDR (unsigned compare).
  - Misaligned when half has off[0] = 1, or word has off[1:0] != 0.
  - If an access is both, misaligned wins (code 1).
- Loads:
  - Byte select by off[1:0], half select by off[1].
  - Sign-extend unless req_unsigned; a word load returns the full word.
- Stores:
  - Byte lane write enable per off[1:0]; a half store writes lanes {1,0} or {3,2}.
  - Other lanes are unchanged; data is taken from req_wdata[7:0] or req_wdata[15:0].
- Word index: off[log2(4*DEPTH_WORDS)-1:2].

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on each committed store, $display("%d@%h: *%h <= %h", $time, req_pc, word-aligned address, merged full 32-bit word after the write).
- Not defined: no display statements are compiled and behaviour is otherwise identical.

Decomposition:
- Shared package dm_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - exception codes EXC_NONE/EXC_MISALIGN/EXC_RANGE;
  - state enum CLEAR/IDLE/WAIT/RESP.
- One sub-module, dm_lane_align (combinational): from offset, size, unsigned flag, wdata and the read word, it produces the byte-lane enables, the merged write word and the extended read data.

Test Plan:
- Reset, then DEPTH_WORDS=16: req_ready stays 0 for 16 cycles after reset_n rises; a lw of address 0x3C then returns 0.
- sw 0x8765_43A1 at 0x10, then lb 0x10 → 0xFFFF_FFA1; lbu 0x11 → 0x0000_0043; lh 0x12 → 0xFFFF_8765; lhu 0x12 → 0x0000_8765.
- sb 0x5A at 0x13 over 0x8765_43A1 → a following lw 0x10 returns 0x5A65_43A1; sh 0xBEEF at 0x10 then gives 0x5A65_BEEF.
- READ_LAT=3, accept lw at cycle N → rsp_valid rises at N+3; hold rsp_ready = 0 for 5 cycles → rsp_* stable and req_ready = 0 throughout.
- lw 0x11 → rsp_exc = 1, code 1, no write. sw at BASE_ADDR + 4*DEPTH_WORDS → code 2 and memory unchanged. sh at 0x0000_FFFF out of range → code 1 (misaligned wins).
- Pull reset_n low while in RESP → rsp_valid drops immediately (asynchronously); after release the CLEAR sweep repeats and the earlier store reads back 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the MEM-stage data-memory controller: access sizes,
// exception codes and controller states.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_RANGE    = 2'd2;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dm_state_e;

    // Reserved size 3 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off_lo[0];
            default: mis = (off_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational sub-word steering: byte-lane enables, store merge into the
// current word, and sign/zero-extended load data.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  off_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic [3:0]  lane_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_ext
);

    logic [31:0] wrep_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, store-data replication and load extension per size.
    always_comb begin
        lane_en = 4'b0000;
        wrep_s  = 32'h0000_0000;
        byte_s  = rd_word[{off_lo, 3'b000} +: 8];
        half_s  = off_lo[1] ? rd_word[31:16] : rd_word[15:0];
        rd_ext  = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                lane_en = 4'b0001 << off_lo;
                wrep_s  = {4{wdata[7:0]}};
                rd_ext  = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SZ_HALF: begin
                lane_en = off_lo[1] ? 4'b1100 : 4'b0011;
                wrep_s  = {2{wdata[15:0]}};
                rd_ext  = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            default: begin
                lane_en = 4'b1111;
                wrep_s  = wdata;
                rd_ext  = rd_word;
            end
        endcase
    end

    // Merge: enabled lanes take store data, the rest keep the current word.
    always_comb begin
        wr_word = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = lane_en[i] ? wrep_s[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_bank_ctrl.sv
// MEM-stage data-memory controller: one outstanding load/store, configurable
// load latency, post-reset clear sweep. Define DM_TRACE_EN to print committed stores.
module dm_bank_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          READ_LAT    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [1:0]  rsp_exc_code,
    output logic [31:0] rsp_pc
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
    localparam logic        LONG_LAT  = (READ_LAT > 1);
    localparam logic [1:0]  WAIT_INIT = 2'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    logic [31:0]   mem_r [DEPTH_WORDS];
    dm_state_e     state_r, state_nxt_s;
    logic [AW-1:0] clr_cnt_r;
    logic [1:0]    wait_cnt_r;

    logic          req_ready_r, rsp_valid_r, rsp_exc_r;
    logic [31:0]   rsp_rdata_r, rsp_pc_r;
    logic [1:0]    rsp_exc_code_r;

    logic [31:0]   off_s, rd_word_s, wr_word_s, rd_ext_s;
    logic [AW-1:0] idx_s;
    logic [3:0]    lane_en_s;
    logic          misalign_s, range_s, fault_s, accept_s, store_s;
    logic [1:0]    exc_code_s;

    assign off_s      = req_addr - BASE_ADDR;
    assign idx_s      = off_s[AW+1:2];
    assign misalign_s = is_misaligned(req_size, off_s[1:0]);
    // Unsigned compare also catches addresses that wrapped below BASE_ADDR.
    assign range_s    = ({1'b0, off_s} >= SPAN);
    assign exc_code_s = misalign_s ? EXC_MISALIGN : (range_s ? EXC_RANGE : EXC_NONE);
    assign fault_s    = (exc_code_s != EXC_NONE);
    assign accept_s   = req_valid & req_ready_r;
    assign store_s    = accept_s & req_we & ~fault_s;
    assign rd_word_s  = mem_r[idx_s];

    dm_lane_align u_lane_align (
        .off_lo      (off_s[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rd_word     (rd_word_s),
        .lane_en     (lane_en_s),
        .wr_word     (wr_word_s),
        .rd_ext      (rd_ext_s)
    );

    // Array writes: zero sweep while clearing, otherwise committed stores.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem_r[clr_cnt_r] <= 32'h0000_0000;
        end else if (store_s) begin
            mem_r[idx_s] <= wr_word_s;
`ifdef DM_TRACE_EN
            $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, wr_word_s);
`endif
        end
    end

    // Next-state decode for the request/response sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_cnt_r == LAST_IDX) state_nxt_s = IDLE;
                else                       state_nxt_s = CLEAR;
            end
            IDLE: begin
                if (accept_s) begin
                    if (!req_we && !fault_s && LONG_LAT) state_nxt_s = WAIT;
                    else                                 state_nxt_s = RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == 2'd0) state_nxt_s = RESP;
                else                    state_nxt_s = WAIT;
            end
            RESP: begin
                if (rsp_ready) state_nxt_s = IDLE;
                else           state_nxt_s = RESP;
            end
            default: state_nxt_s = CLEAR;
        endcase
    end

    // State, sweep and latency counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= CLEAR;
            clr_cnt_r  <= '0;
            wait_cnt_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == CLEAR) clr_cnt_r <= clr_cnt_r + 1'b1;
            if (accept_s) begin
                wait_cnt_r <= WAIT_INIT;
            end else if (state_r == WAIT && wait_cnt_r != 2'd0) begin
                wait_cnt_r <= wait_cnt_r - 2'd1;
            end
        end
    end

    // Registered handshake and response fields; load data captured at accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_r    <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            rsp_exc_r      <= 1'b0;
            rsp_exc_code_r <= EXC_NONE;
            rsp_pc_r       <= 32'h0000_0000;
        end else begin
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            if (accept_s) begin
                rsp_rdata_r    <= (req_we || fault_s) ? 32'h0000_0000 : rd_ext_s;
                rsp_exc_r      <= fault_s;
                rsp_exc_code_r <= exc_code_s;
                rsp_pc_r       <= req_pc;
            end else if (state_r == RESP && rsp_ready) begin
                rsp_rdata_r    <= 32'h0000_0000;
                rsp_exc_r      <= 1'b0;
                rsp_exc_code_r <= EXC_NONE;
                rsp_pc_r       <= 32'h0000_0000;
            end
        end
    end

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign rsp_exc      = rsp_exc_r;
    assign rsp_exc_code = rsp_exc_code_r;
    assign rsp_pc       = rsp_pc_r;

endmodule

// File: tb/tb_dm_bank_ctrl.sv
// Self-checking bench for dm_bank_ctrl (16 words, load latency 3) against a
// word-array reference model, with directed and randomized accesses.
module tb_dm_bank_ctrl;

    localparam int          DW   = 16;
    localparam int          RL   = 3;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, req_pc = 32'h0;
    logic        req_ready, rsp_valid, rsp_exc;
    logic [31:0] rsp_rdata, rsp_pc;
    logic [1:0]  rsp_exc_code;

    logic [31:0] ref_mem [DW];
    int          n_checks = 0;
    int          n_errors = 0;

    dm_bank_ctrl #(.DEPTH_WORDS(DW), .READ_LAT(RL), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_exc(rsp_exc), .rsp_exc_code(rsp_exc_code), .rsp_pc(rsp_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory as a plain word array, sub-word access by shift and mask.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic [1:0] code);
        logic [31:0] off, word, v, mask;
        int          sh, idx, esz;
        off  = addr - BASE;
        esz  = (sz == 2'd3) ? 2 : int'(sz);
        rd   = 32'h0;
        code = 2'd0;
        if ((esz == 1 && off % 2 != 0) || (esz == 2 && off % 4 != 0)) code = 2'd1;
        else if (off >= 32'(DW * 4)) code = 2'd2;
        if (code == 2'd0) begin
            idx  = int'(off / 4);
            sh   = int'(off % 4) * 8;
            word = ref_mem[idx];
            if (we) begin
                mask = (esz == 0) ? 32'hFF : ((esz == 1) ? 32'hFFFF : 32'hFFFF_FFFF);
                mask = mask << sh;
                ref_mem[idx] = (word & ~mask) | ((wdata << sh) & mask);
            end else if (esz == 0) begin
                v = (word >> sh) & 32'hFF;
                if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
                rd = v;
            end else if (esz == 1) begin
                v = (word >> sh) & 32'hFFFF;
                if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
                rd = v;
            end else begin
                rd = word;
            end
        end
    endtask

    // One full transaction: accept, latency, response fields, stability while stalled.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] got, output logic [1:0] got_code);
        logic [31:0] exp_rd, pc;
        logic [1:0]  exp_code;
        int          waited, lat, exp_lat;
        model(we, sz, uns, addr, wdata, exp_rd, exp_code);
        exp_lat = (!we && exp_code == 2'd0) ? RL : 1;
        pc = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) chk("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            chk("busy_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        for (int k = 0; k <= hold; k++) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_ready_low", 32'(req_ready), 32'd0);
            chk("rdata", rsp_rdata, exp_rd);
            chk("exc", 32'(rsp_exc), 32'(exp_code != 2'd0));
            chk("exc_code", 32'(rsp_exc_code), 32'(exp_code));
            chk("pc", rsp_pc, pc);
            if (k < hold) @(negedge clk);
        end
        got = rsp_rdata;
        got_code = rsp_exc_code;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("back_idle", 32'(req_ready), 32'd1);
    endtask

    // Release reset at a negedge and count cycles until the sweep completes.
    task automatic release_and_sweep();
        int n;
        reset_n = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", 32'(n), 32'(DW));
        for (int i = 0; i < DW; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        logic [31:0] got, a, pc;
        logic [1:0]  code;
        int          n;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_exc", {29'h0, rsp_exc, rsp_exc_code}, 32'h0);
        chk("rst_pc", rsp_pc, 32'h0);
        release_and_sweep();

        do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 0, got, code);
        chk("plan_lw3c", got, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8765_43A1, 0, got, code);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, got, code);
        chk("plan_lb", got, 32'hFFFF_FFA1);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, got, code);
        chk("plan_lbu", got, 32'h0000_0043);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, got, code);
        chk("plan_lh", got, 32'hFFFF_8765);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, got, code);
        chk("plan_lhu", got, 32'h0000_8765);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_005A, 0, got, code);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got, code);
        chk("plan_sb", got, 32'h5A65_43A1);
        do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_BEEF, 0, got, code);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got, code);
        chk("plan_sh", got, 32'h5A65_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0, got, code);
        chk("plan_mis_lw", 32'(code), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, BASE + 32'(4 * DW), 32'hDEAD_BEEF, 0, got, code);
        chk("plan_range_sw", 32'(code), 32'd2);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_FFFF, 32'h1234, 0, got, code);
        chk("plan_both", 32'(code), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got, code);
        chk("plan_unchanged", got, 32'h5A65_BEEF);

        // Reset while a response is stalled.
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 0, got, code);
        pc = 32'h0000_4444;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_pc = pc;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_data", rsp_rdata, 32'hCAFE_F00D);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(rsp_valid), 32'd0);
        chk("async_pc", rsp_pc, 32'h0);
        chk("async_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        release_and_sweep();
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got, code);
        chk("post_rst_zero", got, 32'h0);

        // Randomized accesses, mostly in range.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 4 * DW - 1));
            else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(4 * DW, 4 * DW + 40));
            else a = $urandom;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom_range(0, 3), got, code);
        end

        for (int i = 0; i < DW; i++) begin
            do_req(1'b0, 2'd2, 1'b0, BASE + 32'(4 * i), 32'h0, 0, got, code);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
